seg7_display_scheduler: RTL and testbench

//  Time-shares the 4-digit 7-seg driver (16-bit hex word input) between NUM_SRC

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_rr_pick.sv | 25 ++
 rtl/seg7_display_scheduler.sv | 136 +++++++++++++
 tb/tb_seg7_display_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared state encoding and display constants for the 7-segment display scheduler.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_ALERT
    } seg7_state_t;

    localparam int SEG7_W = 16;
    localparam logic [SEG7_W-1:0] BLANK_WORD = 16'h0000;

endpackage

// File: rtl/seg7_rr_pick.sv
// Round-robin picker: finds the first enabled index strictly after cur, wrapping,
// so a lone enabled source picks itself and an empty vector returns cur unchanged.
module seg7_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] en,
    input  logic [SEL_W-1:0]   cur,
    output logic [SEL_W-1:0]   nxt,
    output logic               any_en
);

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves one unassigned infers a latch.
        nxt    = cur;
        any_en = |en;
        // Scan from the farthest offset down so the nearest enabled index wins.
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (en[(int'(cur) + k) % NUM_SRC]) begin
                nxt = SEL_W'((int'(cur) + k) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Time-shares one 4-digit hex display between NUM_SRC sources in round-robin,
// with a one-shot alert word that preempts rotation for ALERT_CYCLES.
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DWELL_CYCLES = 50_000_000,
    parameter  int ALERT_CYCLES = 100_000_000,
    parameter  int CNT_W        = 27,
    localparam int SEL_W        = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [SEG7_W*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_en,
    input  logic                        hold,
    input  logic                        next_btn,
    input  logic                        alert_req,
    input  logic [SEG7_W-1:0]           alert_data,
    output logic                        alert_ack,
    output logic [SEG7_W-1:0]           disp_x,
    output logic [SEL_W-1:0]            disp_sel,
    output logic                        disp_alert,
    output logic                        disp_blank
);

    seg7_state_t       state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt, pick_cur, pick_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [SEG7_W-1:0] alert_word, disp_x_nxt;
    logic              any_en, accept;

    // From IDLE, searching after the top index yields the lowest enabled source.
    assign pick_cur = (state == ST_IDLE) ? SEL_W'(NUM_SRC - 1) : sel;

    seg7_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .en     (src_en),
        .cur    (pick_cur),
        .nxt    (pick_nxt),
        .any_en (any_en)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        timer_nxt = timer;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (alert_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_ALERT;
                    timer_nxt = '0;
                end else if (any_en) begin
                    state_nxt = ST_ROTATE;
                    sel_nxt   = pick_nxt;
                    timer_nxt = '0;
                end
            end
            ST_ROTATE: begin
                // Alert outranks every rotation event in the same cycle.
                if (alert_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_ALERT;
                    timer_nxt = '0;
                end else if (!any_en) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end else if (!src_en[sel] || next_btn ||
                             (!hold && timer == CNT_W'(DWELL_CYCLES - 1))) begin
                    sel_nxt   = pick_nxt;
                    timer_nxt = '0;
                end else if (!hold) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_ALERT: begin
                if (timer == CNT_W'(ALERT_CYCLES - 1)) begin
                    timer_nxt = '0;
                    if (!any_en) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ROTATE;
                        sel_nxt   = src_en[sel] ? sel : pick_nxt;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Display registers track the state being entered, so a new source shows for a full dwell.
    always_comb begin
        disp_x_nxt = BLANK_WORD;
        case (state_nxt)
            ST_ALERT:  disp_x_nxt = accept ? alert_data : alert_word;
            ST_ROTATE: disp_x_nxt = src_data[SEG7_W*int'(sel_nxt) +: SEG7_W];
            default:   disp_x_nxt = BLANK_WORD;
        endcase
    end

    assign alert_ack = accept && !clr;
    assign disp_sel  = sel;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            state      <= ST_IDLE;
            sel        <= '0;
            timer      <= '0;
            disp_x     <= BLANK_WORD;
            disp_alert <= 1'b0;
            disp_blank <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            timer      <= timer_nxt;
            disp_x     <= disp_x_nxt;
            disp_alert <= (state_nxt == ST_ALERT);
            disp_blank <= (state_nxt == ST_IDLE);
        end
    end

    // NOTE: alert_word has no reset; it is always written on accept before it is ever displayed.
    always_ff @(posedge clk) begin
        if (accept) begin
            alert_word <= alert_data;
        end
    end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Self-checking bench for seg7_display_scheduler against a countdown-based behavioural model.
module tb_seg7_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 4;
    localparam int ALERT   = 6;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] src_data;
    logic [3:0]  src_en;
    logic        hold, next_btn, alert_req;
    logic [15:0] alert_data;
    logic        alert_ack;
    logic [15:0] disp_x;
    logic [1:0]  disp_sel;
    logic        disp_alert, disp_blank;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL),
        .ALERT_CYCLES (ALERT),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .src_data   (src_data),
        .src_en     (src_en),
        .hold       (hold),
        .next_btn   (next_btn),
        .alert_req  (alert_req),
        .alert_data (alert_data),
        .alert_ack  (alert_ack),
        .disp_x     (disp_x),
        .disp_sel   (disp_sel),
        .disp_alert (disp_alert),
        .disp_blank (disp_blank)
    );

    // Model: mode 0 = blank, 1 = rotating, 2 = alert; m_left counts cycles remaining.
    int          m_mode  = 0;
    int          m_sel   = 0;
    int          m_left  = 0;
    logic [15:0] m_word  = 16'h0;
    logic [15:0] m_x     = 16'h0;
    logic        m_alert = 1'b0;
    logic        m_blank = 1'b1;
    logic        m_ack   = 1'b0;
    logic        ack_seen = 1'b0;

    function automatic int next_en(int from);
        for (int k = 1; k <= NUM_SRC; k++) begin
            int idx = (from + k) % NUM_SRC;
            if (src_en[idx]) return idx;
        end
        return from;
    endfunction

    function automatic int lowest_en();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_en[i]) return i;
        end
        return 0;
    endfunction

    task automatic start_alert();
        m_mode = 2;
        m_left = ALERT;
        m_word = alert_data;
    endtask

    task automatic model_step();
        if (clr) begin
            m_mode = 0;
            m_sel  = 0;
            m_left = 0;
        end else if (m_mode == 0) begin
            if (alert_req) start_alert();
            else if (src_en != 4'b0) begin
                m_mode = 1;
                m_sel  = lowest_en();
                m_left = DWELL;
            end
        end else if (m_mode == 1) begin
            if (alert_req) start_alert();
            else if (src_en == 4'b0) m_mode = 0;
            else if (!src_en[m_sel] || next_btn) begin
                m_sel  = next_en(m_sel);
                m_left = DWELL;
            end else if (!hold) begin
                m_left--;
                if (m_left == 0) begin
                    m_sel  = next_en(m_sel);
                    m_left = DWELL;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (src_en == 4'b0) m_mode = 0;
                else begin
                    if (!src_en[m_sel]) m_sel = next_en(m_sel);
                    m_mode = 1;
                    m_left = DWELL;
                end
            end
        end
        m_alert = (m_mode == 2);
        m_blank = (m_mode == 0);
        m_x     = (m_mode == 2) ? m_word :
                  (m_mode == 1) ? src_data[16*m_sel +: 16] : 16'h0000;
    endtask

    task automatic tick();
        m_ack = !clr && (m_mode != 2) && alert_req;
        @(negedge clk);
        ack_seen = alert_ack;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [20:0] got_v();
        return {ack_seen, disp_x, disp_sel, disp_alert, disp_blank};
    endfunction

    function automatic logic [20:0] exp_v();
        return {m_ack, m_x, 2'(m_sel), m_alert, m_blank};
    endfunction

    task automatic test_reset();
        clr = 1'b1; src_en = 4'b0; hold = 1'b0; next_btn = 1'b0;
        alert_req = 1'b0; alert_data = 16'h0; src_data = 64'h0;
        tick();
        tick();
        checks++;
        if (disp_blank !== 1'b1 || disp_x !== 16'h0 || ack_seen !== 1'b0 ||
            disp_alert !== 1'b0 || disp_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset: blank=%b x=%h ack=%b alert=%b sel=%0d, want 1 0000 0 0 0",
                     disp_blank, disp_x, ack_seen, disp_alert, disp_sel);
        end
        clr = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL idle: got %h want %h", got_v(), exp_v());
            end
        end
    endtask

    task automatic test_rotation();
        logic [15:0] want [13];
        want = '{16'h1111, 16'h1111, 16'h1111, 16'h1111,
                 16'h2222, 16'h2222, 16'h2222, 16'h2222,
                 16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h1111};
        src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        src_en   = 4'b1011;
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (got_v() !== exp_v() || disp_x !== want[i]) begin
                errors++;
                $display("FAIL rotation cyc%0d: got %h x=%h want %h x=%h",
                         i, got_v(), disp_x, exp_v(), want[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int n = 0; n < 20 && !(m_mode == 1 && m_sel == 1); n++) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL hold_seek: got %h want %h", got_v(), exp_v());
            end
        end
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (got_v() !== exp_v() || disp_x !== 16'h2222) begin
                errors++;
                $display("FAIL hold cyc%0d: got %h x=%h want %h x=2222", i, got_v(), disp_x, exp_v());
            end
        end
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        hold = 1'b0;
        checks++;
        if (got_v() !== exp_v() || disp_x !== 16'h4444) begin
            errors++;
            $display("FAIL hold_next: got %h x=%h want %h x=4444", got_v(), disp_x, exp_v());
        end
    endtask

    task automatic test_alert();
        int n_dead = 0;
        int n_back = 0;
        for (int n = 0; n < 20 && m_sel != 1; n++) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL alert_seek: got %h want %h", got_v(), exp_v());
            end
        end
        alert_req  = 1'b1;
        alert_data = 16'hDEAD;
        tick();
        alert_req = 1'b0;
        checks++;
        if (got_v() !== exp_v() || ack_seen !== 1'b1) begin
            errors++;
            $display("FAIL alert_accept: got %h ack=%b want %h ack=1", got_v(), ack_seen, exp_v());
        end
        if (disp_x === 16'hDEAD && disp_alert === 1'b1) n_dead++;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL alert cyc%0d: got %h want %h", i, got_v(), exp_v());
            end
            if (disp_x === 16'hDEAD && disp_alert === 1'b1) n_dead++;
            if (disp_x === 16'h2222) n_back++;
        end
        checks++;
        if (n_dead != ALERT || n_back != DWELL) begin
            errors++;
            $display("FAIL alert_span: dead=%0d back=%0d want %0d %0d", n_dead, n_back, ALERT, DWELL);
        end
    endtask

    task automatic test_disable();
        for (int n = 0; n < 20 && m_sel != 0; n++) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL dis_seek: got %h want %h", got_v(), exp_v());
            end
        end
        src_en = 4'b1010;
        repeat (2) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL disable: got %h want %h", got_v(), exp_v());
            end
        end
        checks++;
        if (disp_x !== 16'h2222 || disp_sel !== 2'd1) begin
            errors++;
            $display("FAIL disable_skip: x=%h sel=%0d want 2222 1", disp_x, disp_sel);
        end
        src_en = 4'b0;
        tick();
        checks++;
        if (got_v() !== exp_v() || disp_blank !== 1'b1 || disp_x !== 16'h0) begin
            errors++;
            $display("FAIL all_off: got %h want %h blank=1 x=0000", got_v(), exp_v());
        end
    endtask

    task automatic test_clr_alert();
        int rec;
        src_en = 4'b1011;
        repeat (3) tick();
        alert_req  = 1'b1;
        alert_data = 16'hBEEF;
        tick();
        alert_req = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (disp_x !== 16'h0 || disp_blank !== 1'b1 || disp_alert !== 1'b0 ||
            disp_sel !== 2'd0 || ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid_alert: x=%h blank=%b alert=%b sel=%0d ack=%b want 0000 1 0 0 0",
                     disp_x, disp_blank, disp_alert, disp_sel, ack_seen);
        end
        repeat (6) tick();
        rec        = m_sel;
        next_btn   = 1'b1;
        alert_req  = 1'b1;
        alert_data = 16'hCAFE;
        tick();
        next_btn  = 1'b0;
        alert_req = 1'b0;
        checks++;
        if (got_v() !== exp_v() || disp_x !== 16'hCAFE) begin
            errors++;
            $display("FAIL alert_vs_next: got %h x=%h want %h x=CAFE", got_v(), disp_x, exp_v());
        end
        repeat (ALERT) begin
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL alert_vs_next_run: got %h want %h", got_v(), exp_v());
            end
        end
        checks++;
        if (disp_alert !== 1'b0 || disp_sel !== 2'(rec) || disp_x !== src_data[16*rec +: 16]) begin
            errors++;
            $display("FAIL sel_kept: alert=%b sel=%0d x=%h want 0 %0d %h",
                     disp_alert, disp_sel, disp_x, rec, src_data[16*rec +: 16]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) src_en = 4'($urandom);
            src_data = {$urandom, $urandom};
            hold     = ($urandom_range(0, 3) == 0);
            next_btn = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 99) == 0);
            if (!alert_req && $urandom_range(0, 24) == 0) begin
                alert_req  = 1'b1;
                alert_data = 16'($urandom);
            end
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, got_v(), exp_v());
            end
            if (ack_seen) alert_req = 1'b0;
        end
        clr = 1'b0; hold = 1'b0; next_btn = 1'b0; alert_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_alert();
        test_disable();
        test_clr_alert();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
